// File: rtl/audio_pwm_player_pkg.sv
// audio_pkg: shared widths, defaults and types for the audio PWM player.
//   SAMPLE_W / WORD_W  : audio sample and memory word widths
//   CLK_DIV_DEFAULT    : clocks per sample tick (100 MHz -> ~31.5 kHz)
//   UNDERRUN_MAX       : saturation value of the underrun counter
//   byte_sel_t         : which half of the held word plays on the next tick
//   tick_act_t         : what the current sample tick does
package audio_pkg;

    localparam int SAMPLE_W        = 8;
    localparam int WORD_W          = 16;
    localparam int CLK_DIV_DEFAULT = 3175;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    typedef enum logic {
        SEL_HIGH = 1'b0,   // next tick needs a fresh word from the FIFO
        SEL_LOW  = 1'b1    // next tick plays the held low byte
    } byte_sel_t;

    typedef enum logic [1:0] {
        TICK_NONE,
        TICK_LOW,
        TICK_LOAD,
        TICK_UNDERRUN
    } tick_act_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == UNDERRUN_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/audio_pwm_player_sample_fifo.sv
// sample_fifo: first-word fall-through word FIFO, depth 2**FIFO_AW.
//   clk, rst_n : clock, async active-low reset (pointers/count cleared)
//   push, din  : write din when push and not full
//   pop        : discard head when pop and not empty
//   dout       : head word, valid while !empty
//   full,empty : occupancy flags
module sample_fifo
    import audio_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] din,
    input  logic              pop,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        full    = (count == (FIFO_AW + 1)'(DEPTH));
        empty   = (count == '0);
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_pwm_player.sv
// audio_pwm_player: buffers 16-bit words from memory, unpacks each into two
// unsigned 8-bit samples (high byte first) and plays one per sample tick.
//   clk, rst_n    : clock, async active-low reset
//   sample_valid  : word on sample_data offered
//   sample_data   : {first_sample, second_sample}
//   sample_ready  : word accepted on sample_valid & sample_ready (= !full)
//   sample_tick   : one-cycle pulse per sample period
//   pwm_out       : registered audio bitstream
//   amp_en        : amplifier enable, set once playback starts
//   underrun      : one-cycle pulse when a tick found no sample
//   underrun_cnt  : saturating underrun count
// Build option: define AUDIO_SIGMA_DELTA_EN to replace the PWM modulator with a
// first-order sigma-delta modulator; ports and all other behaviour unchanged.
module audio_pwm_player
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        sample_tick,
    output logic        pwm_out,
    output logic        amp_en,
    output logic        underrun,
    output logic [7:0]  underrun_cnt
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]    tick_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [WORD_W-1:0]   fifo_dout;
    logic [SAMPLE_W-1:0] held_low;
    logic [SAMPLE_W-1:0] active;
    byte_sel_t           byte_sel;
    byte_sel_t           byte_sel_next;
    tick_act_t           tick_act;

    sample_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (sample_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        sample_ready = !fifo_full;
        fifo_push    = sample_valid && !fifo_full;
        sample_tick  = (tick_cnt == CNT_W'(CLK_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Unpack FSM: the low byte of a held word always wins over fetching a new
    // word; underruns only count once playback has started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_sel <= SEL_HIGH;
        end else begin
            byte_sel <= byte_sel_next;
        end
    end

    always_comb begin
        byte_sel_next = byte_sel;
        tick_act      = TICK_NONE;
        fifo_pop      = 1'b0;
        if (sample_tick) begin
            if (byte_sel == SEL_LOW) begin
                tick_act      = TICK_LOW;
                byte_sel_next = SEL_HIGH;
            end else if (!fifo_empty) begin
                tick_act      = TICK_LOAD;
                byte_sel_next = SEL_LOW;
                fifo_pop      = 1'b1;
            end else if (amp_en) begin
                tick_act = TICK_UNDERRUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_low     <= '0;
            active       <= '0;
            amp_en       <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= (tick_act == TICK_UNDERRUN);
            case (tick_act)
                TICK_LOW: begin
                    active <= held_low;
                end
                TICK_LOAD: begin
                    held_low <= fifo_dout[SAMPLE_W-1:0];
                    active   <= fifo_dout[WORD_W-1:SAMPLE_W];
                    amp_en   <= 1'b1;
                end
                TICK_UNDERRUN: begin
                    underrun_cnt <= sat_inc(underrun_cnt);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AUDIO_SIGMA_DELTA_EN
    logic [8:0] acc;
    logic [8:0] acc_sum;

    always_comb begin
        acc_sum = {1'b0, acc[7:0]} + {1'b0, active};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pwm_out <= 1'b0;
        end else begin
            acc     <= acc_sum;
            pwm_out <= acc_sum[8];
        end
    end
`else
    logic [7:0] pc;
    logic [7:0] duty;

    // Duty reloads only at the period boundary so a period never mixes samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pc      <= pc + 8'd1;
            pwm_out <= (pc < duty);
            if (pc == 8'hFF) begin
                duty <= active;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_pwm_player.sv
// Self-checking bench for audio_pwm_player (CLK_DIV = 16). A behavioural model
// built on a word queue and elapsed-cycle arithmetic predicts every output each
// cycle; directed checks cover idle, saturation and mid-playback reset.
module tb_audio_pwm_player;

    localparam int CLK_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic        sample_tick;
    logic        pwm_out;
    logic        amp_en;
    logic        underrun;
    logic [7:0]  underrun_cnt;

    int unsigned n_checks = 0;
    int unsigned n_bad = 0;

    audio_pwm_player #(
        .CLK_DIV (CLK_DIV),
        .FIFO_AW (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .sample_tick  (sample_tick),
        .pwm_out      (pwm_out),
        .amp_en       (amp_en),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q[$];
    int unsigned m_n = 0;        // edges since reset release
    bit          m_second = 0;   // low byte of held word still to play
    logic [7:0]  m_low = '0;
    logic [7:0]  m_active = '0;
    logic [7:0]  m_duty = '0;
    bit          m_amp = 0;
    bit          m_und = 0;
    int unsigned m_ucnt = 0;
    bit          m_pwm = 0;
    int unsigned m_acc = 0;
    bit          t_tick;
    bit          t_take;
    logic [7:0]  t_old;
    int unsigned t_sum;
    logic [15:0] t_word;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_n = 0; m_second = 0; m_low = '0; m_active = '0; m_duty = '0;
            m_amp = 0; m_und = 0; m_ucnt = 0; m_pwm = 0; m_acc = 0;
        end else begin
            t_tick = ((m_n % CLK_DIV) == CLK_DIV - 1);
            t_take = sample_valid && (q.size() < 4);
            t_old  = m_active;
`ifdef AUDIO_SIGMA_DELTA_EN
            t_sum = (m_acc % 256) + int'(t_old);
            m_pwm = (t_sum >= 256);
            m_acc = t_sum;
`else
            m_pwm = ((m_n % 256) < int'(m_duty));
            if ((m_n % 256) == 255) m_duty = t_old;
`endif
            m_und = 0;
            if (t_tick) begin
                if (m_second) begin
                    m_active = m_low;
                    m_second = 0;
                end else if (q.size() > 0) begin
                    t_word   = q.pop_front();
                    m_active = t_word[15:8];
                    m_low    = t_word[7:0];
                    m_second = 1;
                    m_amp    = 1;
                end else if (m_amp) begin
                    m_und = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            if (t_take) q.push_back(sample_data);
            m_n++;
        end
    end

    // per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        check("outputs",
              {19'd0, sample_ready, sample_tick, pwm_out, amp_en, underrun, underrun_cnt},
              {19'd0, 1'(q.size() < 4), 1'((m_n % CLK_DIV) == CLK_DIV - 1),
               1'(m_pwm), 1'(m_amp), 1'(m_und), 8'(m_ucnt)});
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_amp", 32'(amp_en), 32'd0);
        check("rst_ucnt", 32'(underrun_cnt), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        cycles(3);
        rst_n = 1'b1;

        // idle: nothing starts, nothing underruns
        cycles(100);
        check("idle_amp", 32'(amp_en), 32'd0);
        check("idle_pwm", 32'(pwm_out), 32'd0);
        check("idle_ucnt", 32'(underrun_cnt), 32'd0);

        // one word, then starve until the counter saturates
        sample_valid = 1'b1;
        sample_data  = 16'hC040;
        cycles(1);
        sample_valid = 1'b0;
        cycles(600);
        check("play_amp", 32'(amp_en), 32'd1);
        cycles(300 * CLK_DIV);
        check("ucnt_sat", 32'(underrun_cnt), 32'd255);

        // reset mid-playback, FIFO contents discarded
        sample_valid = 1'b1;
        sample_data  = 16'h1234;
        cycles(2);
        sample_valid = 1'b0;
        mid_reset();
        cycles(3 * CLK_DIV);
        check("post_rst_amp", 32'(amp_en), 32'd0);

        // fill the FIFO and hold valid across several pops
        sample_valid = 1'b1;
        for (int unsigned i = 0; i < 8 * CLK_DIV; i++) begin
            sample_data = 16'($urandom);
            cycles(1);
        end
        sample_valid = 1'b0;
        cycles(10 * CLK_DIV);

        // random traffic: busy, then sparse (drains and underruns), sporadic resets
        for (int unsigned i = 0; i < 4000; i++) begin
            sample_valid = (i < 2000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 63) == 0);
            sample_data  = 16'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                sample_valid = 1'b0;
                mid_reset();
            end else begin
                cycles(1);
            end
        end
        sample_valid = 1'b0;
        cycles(600);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
